// File: rtl/mcu_spi_phy.sv
// Pin-side SPI PHY between the cartridge RTC command engine and the on-cart MCU.
// Gates SClk into the MCU SPI clock, cleans up the asynchronous MCU ready pin,
// supervises clock stretch with a watchdog and counts clocked bits per frame.
module mcu_spi_phy #(
  parameter int DEGLITCH = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic       SClk,
  input  logic       Reset,
  input  logic       SPIClkRunning,
  input  logic       SPIClkStretch,
  input  logic       nMCUSel,
  input  logic       MCUReadyPin,
  output logic       MCUSPIClk,
  output logic       MCUReadyFallingEdge,
  output logic       StretchTimeout,
  output logic       StretchAbort,
  input  logic       TimeoutClear,
  output logic [6:0] FrameBits,
  output logic       FrameDone
);

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [3:0]      DG_LAST = 4'(DEGLITCH - 1);

  logic            clk_en;
  logic            ready_s1;
  logic            ready_s2;
  logic            ready_filt;
  logic            ready_filt_prev;
  logic [3:0]      dg_cnt;
  logic            stretching;
  logic            wd_fire;
  logic            wd_fired;
  logic [WD_W-1:0] wd_cnt;
  logic            nsel_prev;
  logic            frame_active;
  logic            cs_fall;
  logic            cs_rise;
  logic [6:0]      live_cnt;
  logic [6:0]      live_next;

  // All gate inputs move only at posedge SClk, i.e. while ~SClk is low, so
  // the AND cannot glitch. Reset kills the clock in the same cycle.
  assign clk_en    = SPIClkRunning & ~SPIClkStretch & ~nMCUSel & ~Reset;
  assign MCUSPIClk = clk_en & ~SClk;

  // Synchronise the ready pin and accept a new level only after it has
  // differed from the filtered level for DEGLITCH consecutive cycles.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      ready_s1        <= 1'b1;
      ready_s2        <= 1'b1;
      ready_filt      <= 1'b1;
      ready_filt_prev <= 1'b1;
      dg_cnt          <= 4'd0;
    end else begin
      ready_s1        <= MCUReadyPin;
      ready_s2        <= ready_s1;
      ready_filt_prev <= ready_filt;
      if (ready_s2 != ready_filt) begin
        if (dg_cnt == DG_LAST) begin
          ready_filt <= ready_s2;
          dg_cnt     <= 4'd0;
        end else begin
          dg_cnt <= dg_cnt + 4'd1;
        end
      end else begin
        dg_cnt <= 4'd0;
      end
    end
  end

  assign MCUReadyFallingEdge = ready_filt_prev & ~ready_filt;

  // Stretch watchdog: fires once per continuous stretch, then holds until
  // the stretch drops. A set in the same cycle as a clear keeps the flag.
  assign stretching = SPIClkStretch & ~nMCUSel;
  assign wd_fire    = stretching & (wd_cnt == WD_LAST) & ~wd_fired;

  always_ff @(posedge SClk) begin
    if (Reset) begin
      wd_cnt         <= '0;
      wd_fired       <= 1'b0;
      StretchTimeout <= 1'b0;
      StretchAbort   <= 1'b0;
    end else begin
      StretchAbort <= wd_fire;
      if (!stretching) begin
        wd_cnt   <= '0;
        wd_fired <= 1'b0;
      end else if (wd_cnt == WD_LAST) begin
        wd_fired <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_fire) begin
        StretchTimeout <= 1'b1;
      end else if (TimeoutClear) begin
        StretchTimeout <= 1'b0;
      end
    end
  end

  assign cs_fall   = nsel_prev & ~nMCUSel;
  assign cs_rise   = ~nsel_prev & nMCUSel;
  assign live_next = (clk_en && (live_cnt != 7'd127)) ? live_cnt + 7'd1 : live_cnt;

  // Frame bit counter. A frame only reports if its falling chip-select edge
  // was seen after the last reset, so an aborted frame never pulses FrameDone.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      nsel_prev    <= 1'b1;
      frame_active <= 1'b0;
      live_cnt     <= 7'd0;
      FrameBits    <= 7'd0;
      FrameDone    <= 1'b0;
    end else begin
      nsel_prev <= nMCUSel;
      FrameDone <= 1'b0;
      if (cs_fall) begin
        live_cnt     <= 7'd0;
        frame_active <= 1'b1;
      end else begin
        live_cnt <= live_next;
      end
      if (cs_rise && frame_active) begin
        FrameBits    <= live_next;
        FrameDone    <= 1'b1;
        frame_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcu_spi_phy.sv
// Scoreboard bench for mcu_spi_phy: stimulus pushes expected events into
// queues, a monitor pops and compares whenever the DUT presents one.
module tb_mcu_spi_phy;

  localparam int DEGLITCH = 2;
  localparam int TIMEOUT  = 8;

  logic       SClk = 1'b0;
  logic       Reset = 1'b1;
  logic       SPIClkRunning = 1'b0;
  logic       SPIClkStretch = 1'b0;
  logic       nMCUSel = 1'b1;
  logic       MCUReadyPin = 1'b1;
  logic       TimeoutClear = 1'b0;
  logic       MCUSPIClk;
  logic       MCUReadyFallingEdge;
  logic       StretchTimeout;
  logic       StretchAbort;
  logic [6:0] FrameBits;
  logic       FrameDone;

  mcu_spi_phy #(.DEGLITCH(DEGLITCH), .TIMEOUT(TIMEOUT)) dut (
    .SClk(SClk), .Reset(Reset), .SPIClkRunning(SPIClkRunning),
    .SPIClkStretch(SPIClkStretch), .nMCUSel(nMCUSel), .MCUReadyPin(MCUReadyPin),
    .MCUSPIClk(MCUSPIClk), .MCUReadyFallingEdge(MCUReadyFallingEdge),
    .StretchTimeout(StretchTimeout), .StretchAbort(StretchAbort),
    .TimeoutClear(TimeoutClear), .FrameBits(FrameBits), .FrameDone(FrameDone)
  );

  always #5 SClk = ~SClk;

  int cyc = 0;
  always @(posedge SClk) cyc <= cyc + 1;

  int gcnt = 0;
  always @(posedge MCUSPIClk) gcnt++;

  int checks = 0;
  int errors = 0;

  int exp_ready[$];
  int exp_abort[$];
  int exp_frame[$];
  bit exp_to = 1'b0;

  int model_bits;
  int str_run;
  int gclk_start;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge SClk);
    #1;
  endtask

  // One engine cycle; the model counts clocked bits and continuous stretch.
  task automatic cyc_drive(input bit run, input bit str, input bit clr);
    bit fire;
    SPIClkRunning = run;
    SPIClkStretch = str;
    TimeoutClear  = clr;
    if (!nMCUSel && run && !str) model_bits++;
    fire = 1'b0;
    if (!nMCUSel && str) begin
      str_run++;
      if (str_run == TIMEOUT) fire = 1'b1;
    end else begin
      str_run = 0;
    end
    if (fire) exp_abort.push_back(cyc + 1);
    tick();
    if (fire) exp_to = 1'b1;
    else if (clr) exp_to = 1'b0;
  endtask

  task automatic begin_frame();
    nMCUSel    = 1'b0;
    cyc_drive(1'b0, 1'b0, 1'b0);
    model_bits = 0;
    gclk_start = gcnt;
  endtask

  task automatic end_frame();
    int n;
    n = model_bits;
    nMCUSel = 1'b1;
    exp_frame.push_back(n > 127 ? 127 : n);
    cyc_drive(1'b0, 1'b0, 1'b0);
    check("spi_clk_pulses", gcnt - gclk_start, n);
  endtask

  task automatic ready_trial(input int w);
    int c;
    c = cyc;
    MCUReadyPin = 1'b0;
    if (w >= DEGLITCH) exp_ready.push_back(c + 2 + DEGLITCH);
    repeat (w) tick();
    MCUReadyPin = 1'b1;
    repeat (2 * DEGLITCH + 6) tick();
  endtask

  task automatic stretch_test(input int len, input bit clr_on_set);
    begin_frame();
    for (int k = 1; k <= len; k++) begin
      cyc_drive(1'b0, 1'b1, clr_on_set && (k == TIMEOUT));
      if (clr_on_set && k == TIMEOUT) check("timeout_set_wins", StretchTimeout, 1);
    end
    cyc_drive(1'b0, 1'b0, 1'b0);
    end_frame();
    cyc_drive(1'b0, 1'b0, 1'b1);
    check("timeout_cleared", StretchTimeout, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge SClk);
      #1;
      if (MCUReadyFallingEdge) begin
        if (exp_ready.size() == 0) check("ready_unexpected", 1, 0);
        else check("ready_pulse_cycle", cyc, exp_ready.pop_front());
      end
      if (StretchAbort) begin
        if (exp_abort.size() == 0) check("abort_unexpected", 1, 0);
        else check("abort_cycle", cyc, exp_abort.pop_front());
      end
      if (FrameDone) begin
        if (exp_frame.size() == 0) check("framedone_unexpected", 1, 0);
        else check("frame_bits", int'(FrameBits), exp_frame.pop_front());
      end
      check("stretch_timeout", int'(StretchTimeout), int'(exp_to));
      if (Reset) check("spi_clk_in_reset", int'(MCUSPIClk), 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int g0;
    model_bits = 0;
    str_run    = 0;

    // Reset with inputs toggling
    for (int i = 0; i < 6; i++) begin
      SPIClkRunning = 1'($urandom);
      SPIClkStretch = 1'($urandom);
      nMCUSel       = 1'($urandom);
      MCUReadyPin   = 1'($urandom);
      TimeoutClear  = 1'($urandom);
      tick();
    end
    Reset = 1'b0;
    SPIClkRunning = 1'b0;
    SPIClkStretch = 1'b0;
    nMCUSel = 1'b1;
    MCUReadyPin = 1'b1;
    TimeoutClear = 1'b0;
    check("rst_spi_clk", int'(MCUSPIClk), 0);
    check("rst_ready_edge", int'(MCUReadyFallingEdge), 0);
    check("rst_timeout", int'(StretchTimeout), 0);
    check("rst_frame_bits", int'(FrameBits), 0);
    check("rst_frame_done", int'(FrameDone), 0);
    repeat (3) tick();

    // Ready deglitch: short glitch, boundary width, long hold, random widths
    ready_trial(1);
    ready_trial(DEGLITCH - 1);
    ready_trial(DEGLITCH);
    ready_trial(10);
    for (int i = 0; i < 8; i++) ready_trial($urandom_range(1, 5));

    // 8 clocks, 3 stretch, 8 clocks
    begin_frame();
    repeat (8) cyc_drive(1'b1, 1'b0, 1'b0);
    repeat (3) cyc_drive(1'b1, 1'b1, 1'b0);
    repeat (8) cyc_drive(1'b1, 1'b0, 1'b0);
    end_frame();

    // Zero-length frame, 64-bit status frame, saturating 200-bit frame
    begin_frame();
    end_frame();
    begin_frame();
    repeat (64) cyc_drive(1'b1, 1'b0, 1'b0);
    end_frame();
    begin_frame();
    repeat (200) cyc_drive(1'b1, 1'b0, 1'b0);
    end_frame();

    // Random frames
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(0, 40);
      begin_frame();
      for (int i = 0; i < len; i++)
        cyc_drive(($urandom % 4) != 0, ($urandom % 4) == 0, 1'b0);
      end_frame();
      repeat ($urandom_range(0, 3)) cyc_drive(1'b0, 1'b0, 1'b0);
    end

    // Watchdog
    stretch_test(20, 1'b1);
    stretch_test(TIMEOUT - 1, 1'b0);
    stretch_test(TIMEOUT, 1'b0);
    for (int i = 0; i < 4; i++) stretch_test($urandom_range(2, 20), 1'b0);

    // Reset mid-frame after 5 clocks
    begin_frame();
    repeat (5) cyc_drive(1'b1, 1'b0, 1'b0);
    Reset = 1'b1;
    g0 = gcnt;
    tick();
    check("rst_midframe_no_clk", gcnt - g0, 0);
    exp_to = 1'b0;
    str_run = 0;
    nMCUSel = 1'b1;
    SPIClkRunning = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    check("rst_midframe_bits", int'(FrameBits), 0);
    begin_frame();
    repeat (8) cyc_drive(1'b1, 1'b0, 1'b0);
    end_frame();

    repeat (10) tick();
    check("ready_queue_empty", exp_ready.size(), 0);
    check("abort_queue_empty", exp_abort.size(), 0);
    check("frame_queue_empty", exp_frame.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_spi_phy.md
Name: mcu_spi_phy

Overview:
- Pin-side SPI PHY between the cartridge RTC command engine and the on-cart MCU.
- Gates SClk into the MCU SPI clock from the engine's SPIClkRunning/SPIClkStretch.
- Synchronises and deglitches the asynchronous MCU ready pin and produces MCUReadyFallingEdge for the engine.
- Supervises clock stretch with a watchdog and counts clocked bits per chip-select frame for status and debug.

Parameters:
DEGLITCH, 2, consecutive SClk cycles a synchronised ready level must differ from the filtered level before it is accepted (range 1..15)
TIMEOUT, 4096, SClk cycles of continuous stretch with nMCUSel low before the watchdog fires (>=2)

Ports:
SClk  in  1  system clock; all flops on posedge
Reset  in  1  synchronous active-high reset
SPIClkRunning  in  1  engine shifting; driven by a posedge-SClk flop
SPIClkStretch  in  1  engine waiting between bytes; driven by a posedge-SClk flop
nMCUSel  in  1  engine chip select, active low; driven by a posedge-SClk flop
MCUReadyPin  in  1  asynchronous MCU ready pin, idle high
MCUSPIClk  out  1  SPI clock to MCU, idle low
MCUReadyFallingEdge  out  1  one-cycle pulse on accepted high-to-low ready transition
StretchTimeout  out  1  sticky watchdog flag
StretchAbort  out  1  one-cycle pulse when the watchdog fires
TimeoutClear  in  1  clears StretchTimeout
FrameBits  out  7  bits clocked in the last completed frame
FrameDone  out  1  one-cycle pulse on nMCUSel rising edge

Behaviour:
- Reset values:
  - sync flops and filtered ready level = 1
  - deglitch counter = 0; stretch counter = 0
  - StretchTimeout = 0; StretchAbort = 0
  - FrameBits = 0; live bit count = 0; FrameDone = 0
  - nMCUSel_prev = 1
- Clock gate: ClkEn = SPIClkRunning & ~SPIClkStretch & ~nMCUSel & ~Reset.
  - MCUSPIClk = ClkEn & ~SClk, combinational.
  - This is glitch-free because all gate inputs change only at posedge SClk, while ~SClk is low.
  - One MCUSPIClk pulse per SClk cycle with ClkEn=1; the rising edge falls mid-bit (SPI mode 0 relative to engine data launched at posedge).
- Ready path:
  - 2-flop synchroniser s1 -> s2.
  - Filter: while s2 != filt, the counter increments. When the counter is at DEGLITCH-1 and the levels still differ, filt <= s2 and the counter clears. Any cycle with s2 == filt clears the counter.
  - MCUReadyFallingEdge = filt_prev & ~filt, high exactly one cycle.
  - Latency: pin low captured at edge 0 -> pulse high in the cycle after edge 1+DEGLITCH.
  - Rising transitions are filtered the same way and produce no pulse.
- Watchdog:
  - The counter increments each cycle with SPIClkStretch & ~nMCUSel; it clears otherwise.
  - When the counter reaches TIMEOUT-1 while still stretching: StretchTimeout <= 1, StretchAbort pulses one cycle, and the counter holds (no repeated pulse until stretch drops).
  - TimeoutClear clears StretchTimeout. If it coincides with a set, set wins.
- Frame counter:
  - On nMCUSel falling (prev=1, now 0): live count <= 0.
  - Otherwise the count increments each cycle with ClkEn=1, saturating at 127.
  - On nMCUSel rising: FrameBits <= live count (including a ClkEn in that same cycle, if any) and FrameDone pulses one cycle.
  - A zero-length frame (CS low, no clocks) yields FrameBits=0 with a FrameDone pulse.
- Reset mid-frame:
  - MCUSPIClk forced low from the reset cycle onward.
  - All state returns to reset values; no FrameDone pulse is emitted for the aborted frame.
  - The first frame after reset needs a fresh nMCUSel falling edge to be counted.

Test Plan:
- Reset with all inputs toggling -> MCUSPIClk=0, MCUReadyFallingEdge=0, StretchTimeout=0, FrameBits=0, FrameDone=0.
- DEGLITCH=2, MCUReadyPin low for 1 cycle then high -> no pulse. Held low -> single pulse in the cycle after edge 3 from capture.
- nMCUSel low, Running=1 for 8 cycles, Stretch=1 for 3, Running=1 for 8, nMCUSel high -> exactly 16 MCUSPIClk pulses, none during stretch, FrameBits=16, one FrameDone.
- 8-byte status frame (64 clocked cycles) -> FrameBits=64. A frame of 200 clocked cycles -> FrameBits=127 (saturation).
- TIMEOUT=8, stretch held 20 cycles -> StretchTimeout set and StretchAbort pulsing once, both in the cycle after the 8th stretch cycle. TimeoutClear asserted on that same set cycle -> flag stays 1. Clear later -> 0.
- Reset asserted mid-frame after 5 clocks -> MCUSPIClk low immediately, no FrameDone. Next frame of 8 clocks -> FrameBits=8.
